// File: rtl/axis_noc_tx.sv
// axis_noc_tx: user-side injector feeding one NoC router input port.
// Buffers user words in a small FIFO and sends one commanded packet at a time on an AXI-Stream lane.
// Ports: clk_noc and rst (async, active-high);
//   usr_valid/usr_ready/usr_data: user data words into the FIFO;
//   cmd_valid/cmd_ready/cmd_dest/cmd_id/cmd_len: packet command, where cmd_len is beats minus one;
//   axis_out_*: stream toward the router;
//   busy: high while a packet is being sent;
//   fifo_count: current FIFO occupancy.
module axis_noc_tx #(
  parameter int DATA_W     = 32,
  parameter int TID_W      = 2,
  parameter int TDEST_W    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic                          clk_noc,
  input  logic                          rst,
  input  logic                          usr_valid,
  output logic                          usr_ready,
  input  logic [DATA_W-1:0]             usr_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [TDEST_W-1:0]            cmd_dest,
  input  logic [TID_W-1:0]              cmd_id,
  input  logic [LEN_W-1:0]              cmd_len,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  output logic [DATA_W-1:0]             axis_out_tdata,
  output logic                          axis_out_tlast,
  output logic [TID_W-1:0]              axis_out_tid,
  output logic [TDEST_W-1:0]            axis_out_tdest,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q;
  logic [TDEST_W-1:0]  dest_q;
  logic [TID_W-1:0]    id_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                load;
  logic                push, pop;

  assign usr_ready      = (cnt_q != CW'(FIFO_DEPTH));
  assign push           = usr_valid & usr_ready;
  assign pop            = axis_out_tvalid & axis_out_tready;
  assign fifo_count     = cnt_q;
  assign axis_out_tdata = mem_q[rd_q];
  assign axis_out_tid   = id_q;
  assign axis_out_tdest = dest_q;

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    load            = 1'b0;
    cmd_ready       = 1'b0;
    axis_out_tvalid = 1'b0;
    axis_out_tlast  = 1'b0;
    busy            = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load    = 1'b1;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        busy            = 1'b1;
        // Only a pop can empty the FIFO, so tvalid never drops early.
        axis_out_tvalid = (cnt_q != '0);
        // beat_q is LEN_W wide, so it reaches 2^LEN_W-1 before wrapping.
        axis_out_tlast  = axis_out_tvalid && (beat_q == len_q);
        if (axis_out_tvalid && axis_out_tready) begin
          beat_d = beat_q + 1'b1;
          if (axis_out_tlast) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (load) begin
        len_q  <= cmd_len;
        id_q   <= cmd_id;
        dest_q <= cmd_dest;
      end
    end
  end

  // Storage is cleared too, so tdata reads zero after reset.
  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= usr_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_axis_noc_tx.sv
// tb_axis_noc_tx: scenario tests for axis_noc_tx.
// Compares the DUT against a packet-level queue model.
module tb_axis_noc_tx;
  localparam int DATA_W = 32;
  localparam int TID_W = 2;
  localparam int TDEST_W = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int LEN_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0]  d;
    logic               l;
    logic [TID_W-1:0]   id;
    logic [TDEST_W-1:0] dest;
  } beat_t;

  logic clk_noc = 1'b0;
  logic rst = 1'b0;
  logic usr_valid = 1'b0;
  logic usr_ready;
  logic [DATA_W-1:0] usr_data = '0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [TDEST_W-1:0] cmd_dest = '0;
  logic [TID_W-1:0] cmd_id = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic axis_out_tvalid;
  logic axis_out_tready = 1'b0;
  logic [DATA_W-1:0] axis_out_tdata;
  logic axis_out_tlast;
  logic [TID_W-1:0] axis_out_tid;
  logic [TDEST_W-1:0] axis_out_tdest;
  logic busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  axis_noc_tx #(
    .DATA_W(DATA_W), .TID_W(TID_W), .TDEST_W(TDEST_W),
    .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk_noc(clk_noc), .rst(rst),
    .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_data(usr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest),
    .cmd_id(cmd_id), .cmd_len(cmd_len),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk_noc = ~clk_noc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DATA_W-1:0] m_q[$];
  bit m_send = 0;
  int m_len = 0;
  int m_beat = 0;
  logic [TID_W-1:0] m_id = '0;
  logic [TDEST_W-1:0] m_dest = '0;

  beat_t obs[$];
  beat_t exp_q[$];
  int obs_cyc[$];

  task automatic model_clear();
    m_q.delete();
    m_send = 0;
    m_len = 0;
    m_beat = 0;
    m_id = '0;
    m_dest = '0;
  endtask

  task automatic clr();
    obs.delete();
    exp_q.delete();
    obs_cyc.delete();
  endtask

  // One clock: called at a falling edge; records beats; returns at the next falling edge.
  task automatic step();
    bit ev, pop, push, acc;
    logic [DATA_W-1:0] pd;
    beat_t b;
    ev = m_send && (m_q.size() != 0);
    pop = ev && axis_out_tready;
    push = usr_valid && (m_q.size() < FIFO_DEPTH);
    acc = !m_send && cmd_valid;
    pd = usr_data;
    if (axis_out_tvalid && axis_out_tready) begin
      b = '{axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest};
      obs.push_back(b);
      obs_cyc.push_back(cyc);
    end
    if (pop) begin
      b.d = m_q[0];
      b.l = (m_beat == m_len);
      b.id = m_id;
      b.dest = m_dest;
      exp_q.push_back(b);
      void'(m_q.pop_front());
      m_beat++;
      if (b.l) m_send = 0;
    end
    if (push) m_q.push_back(pd);
    if (acc) begin
      m_send = 1;
      m_len = int'(cmd_len);
      m_beat = 0;
      m_id = cmd_id;
      m_dest = cmd_dest;
    end
    @(posedge clk_noc);
    @(negedge clk_noc);
    cyc++;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk_noc);
    checks++;
    if ({axis_out_tvalid, axis_out_tlast, busy, fifo_count,
         axis_out_tid, axis_out_tdest, axis_out_tdata} !== '0)
      begin errors++; $display("FAIL reset_outs: tv=%b tl=%b busy=%b cnt=%0d tid=%h tdest=%h td=%h want all 0",
        axis_out_tvalid, axis_out_tlast, busy, fifo_count, axis_out_tid, axis_out_tdest, axis_out_tdata); end
    rst = 1'b0;
    model_clear();
    @(negedge clk_noc);
    checks++;
    if ({usr_ready, cmd_ready} !== 2'b11)
      begin errors++; $display("FAIL reset_ready: usr_ready=%b cmd_ready=%b want 1 1", usr_ready, cmd_ready); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] ed;
    clr();
    axis_out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      usr_valid = 1'b1; usr_data = 32'hA0 + i; step();
    end
    usr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'd5; cmd_id = 2'd2; cmd_len = 8'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ed = 32'hA0 + i;
      checks++;
      if ({axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest, busy}
          !== {1'b1, ed, (i == 3), 2'd2, 4'd5, 1'b1})
        begin errors++; $display("FAIL basic_beat%0d: tv=%b td=%h tl=%b tid=%0d tdest=%0d busy=%b want 1 %h %b 2 5 1",
          i, axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest, busy, ed, (i == 3)); end
      step();
    end
    checks++;
    if ({busy, cmd_ready, axis_out_tvalid, fifo_count} !== {1'b0, 1'b1, 1'b0, 4'd0})
      begin errors++; $display("FAIL basic_end: busy=%b cmd_ready=%b tv=%b cnt=%0d want 0 1 0 0",
        busy, cmd_ready, axis_out_tvalid, fifo_count); end
    checks++;
    if (obs.size() != 4 || obs != exp_q)
      begin errors++; $display("FAIL basic_stream: got %0d beats, model %0d beats", obs.size(), exp_q.size()); end
  endtask

  task automatic test_single();
    clr();
    usr_valid = 1'b1; usr_data = 32'h11; step();
    usr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'd1; cmd_id = 2'd1; cmd_len = 8'd0;
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({axis_out_tvalid, axis_out_tdata, axis_out_tlast} !== {1'b1, 32'h11, 1'b1})
      begin errors++; $display("FAIL single_beat: tv=%b td=%h tl=%b want 1 11 1",
        axis_out_tvalid, axis_out_tdata, axis_out_tlast); end
    step();
    checks++;
    if ({busy, cmd_ready, fifo_count} !== {1'b0, 1'b1, 4'd0})
      begin errors++; $display("FAIL single_idle: busy=%b cmd_ready=%b cnt=%0d want 0 1 0",
        busy, cmd_ready, fifo_count); end
  endtask

  task automatic test_full_stall();
    logic [DATA_W-1:0] w [8];
    int n;
    clr();
    axis_out_tready = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'd3; cmd_id = 2'd1; cmd_len = 8'd7;
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({busy, axis_out_tvalid} !== 2'b10)
      begin errors++; $display("FAIL stall_empty: busy=%b tv=%b want 1 0", busy, axis_out_tvalid); end
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      usr_valid = 1'b1; usr_data = w[i]; step();
    end
    usr_data = $urandom;
    checks++;
    if ({usr_ready, fifo_count} !== {1'b0, 4'd8})
      begin errors++; $display("FAIL stall_full: usr_ready=%b cnt=%0d want 0 8", usr_ready, fifo_count); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({axis_out_tvalid, axis_out_tdata, usr_ready} !== {1'b1, w[0], 1'b0})
        begin errors++; $display("FAIL stall_hold%0d: tv=%b td=%h usr_ready=%b want 1 %h 0",
          i, axis_out_tvalid, axis_out_tdata, usr_ready, w[0]); end
      step();
    end
    usr_valid = 1'b0;
    axis_out_tready = 1'b1;
    n = 0;
    while (m_send && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL stall_drain_timeout: cycles=%0d limit 20", n); end
    checks++;
    if (obs.size() != 8 || obs != exp_q)
      begin errors++; $display("FAIL stall_stream: got %0d beats, model %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      checks++;
      if ({obs[i].d, obs[i].l} !== {w[i], (i == 7)})
        begin errors++; $display("FAIL stall_order%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].l, w[i], (i == 7)); end
    end
  endtask

  task automatic test_underflow();
    int pushed, n;
    bit gap;
    clr();
    axis_out_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      usr_valid = 1'b1; usr_data = 32'hB0 + i; step();
    end
    usr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'd6; cmd_id = 2'd3; cmd_len = 8'd5;
    step();
    cmd_valid = 1'b0;
    pushed = 0; n = 0; gap = 0;
    while ((m_send || pushed < 4) && n < 40) begin
      usr_valid = (n % 3 == 0) && (pushed < 4);
      usr_data = 32'hB2 + pushed;
      checks++;
      if (axis_out_tvalid !== (m_send && m_q.size() != 0))
        begin errors++; $display("FAIL under_tvalid%0d: tv=%b want %b", n, axis_out_tvalid, (m_send && m_q.size() != 0)); end
      if (m_send && m_q.size() == 0) gap = 1;
      step();
      if (usr_valid) pushed++;
      n++;
    end
    usr_valid = 1'b0;
    checks++;
    if (n >= 40 || !gap)
      begin errors++; $display("FAIL under_run: cycles=%0d gap=%b want <40 and 1", n, gap); end
    checks++;
    if (obs.size() != 6 || obs != exp_q)
      begin errors++; $display("FAIL under_stream: got %0d beats, model %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      checks++;
      if ({obs[i].d, obs[i].l} !== {32'hB0 + i, (i == 5)})
        begin errors++; $display("FAIL under_order%0d: got %h/%b want %h/%b", i, obs[i].d, obs[i].l, 32'hB0 + i, (i == 5)); end
    end
  endtask

  task automatic test_back_to_back();
    int acc, n;
    bit a;
    clr();
    axis_out_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      usr_valid = 1'b1; usr_data = 32'hC0 + i; step();
    end
    usr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'd7; cmd_id = 2'd1; cmd_len = 8'd2;
    acc = 0; n = 0;
    while ((acc < 2 || m_send) && n < 30) begin
      if (acc == 1 && m_send) begin
        checks++;
        if ({axis_out_tid, axis_out_tdest} !== {2'd1, 4'd7})
          begin errors++; $display("FAIL b2b_hold%0d: tid=%0d tdest=%0d want 1 7", n, axis_out_tid, axis_out_tdest); end
      end
      a = cmd_valid && !m_send;
      step();
      n++;
      if (a) begin
        acc++;
        if (acc == 1) begin cmd_dest = 4'd9; cmd_id = 2'd3; end
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (n >= 30) begin errors++; $display("FAIL b2b_timeout: cycles=%0d limit 30", n); end
    checks++;
    if (obs.size() != 6 || obs != exp_q)
      begin errors++; $display("FAIL b2b_stream: got %0d beats, model %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      checks++;
      if ({obs[i].d, obs[i].l, obs[i].id, obs[i].dest} !==
          {32'hC0 + i, (i % 3 == 2), (i < 3) ? 2'd1 : 2'd3, (i < 3) ? 4'd7 : 4'd9})
        begin errors++; $display("FAIL b2b_beat%0d: got d=%h l=%b id=%0d dest=%0d", i, obs[i].d, obs[i].l, obs[i].id, obs[i].dest); end
    end
    if (obs.size() == 6) begin
      checks++;
      if (obs_cyc[3] - obs_cyc[2] != 2)
        begin errors++; $display("FAIL b2b_bubble: gap=%0d cycles want 2", obs_cyc[3] - obs_cyc[2]); end
    end
  endtask

  task automatic test_max_len();
    int pushed, n, lasts;
    bit ok;
    clr();
    axis_out_tready = 1'b1;
    cmd_valid = 1'b1; cmd_dest = 4'd15; cmd_id = 2'd0; cmd_len = 8'd255;
    step();
    cmd_valid = 1'b0;
    pushed = 0; n = 0;
    while (m_send && n < 600) begin
      usr_valid = (pushed < 256);
      usr_data = pushed;
      ok = usr_valid && (m_q.size() < FIFO_DEPTH);
      step();
      if (ok) pushed++;
      n++;
    end
    usr_valid = 1'b0;
    checks++;
    if (n >= 600) begin errors++; $display("FAIL maxlen_timeout: cycles=%0d limit 600", n); end
    lasts = 0;
    for (int i = 0; i < obs.size(); i++) if (obs[i].l) lasts++;
    checks++;
    if (obs.size() != 256 || obs != exp_q || lasts != 1)
      begin errors++; $display("FAIL maxlen_stream: beats=%0d lasts=%0d want 256 1", obs.size(), lasts); end
    if (obs.size() == 256) begin
      checks++;
      if ({obs[255].d, obs[255].l} !== {32'd255, 1'b1})
        begin errors++; $display("FAIL maxlen_last: got %h/%b want ff/1", obs[255].d, obs[255].l); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clr();
    axis_out_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      usr_valid = 1'b1; usr_data = 32'hD0 + i; step();
    end
    usr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'd2; cmd_id = 2'd2; cmd_len = 8'd7;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({axis_out_tvalid, fifo_count, busy} !== {1'b0, 4'd0, 1'b0})
      begin errors++; $display("FAIL midrst_async: tv=%b cnt=%0d busy=%b want 0 0 0", axis_out_tvalid, fifo_count, busy); end
    model_clear();
    @(negedge clk_noc);
    rst = 1'b0;
    clr();
    for (int i = 0; i < 2; i++) begin
      usr_valid = 1'b1; usr_data = 32'hE0 + i; step();
    end
    usr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'd4; cmd_id = 2'd1; cmd_len = 8'd1;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (m_send && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20 || obs.size() != 2 || obs != exp_q)
      begin errors++; $display("FAIL midrst_new: cycles=%0d beats=%0d model %0d", n, obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      checks++;
      if ({obs[i].d, obs[i].l, obs[i].dest} !== {32'hE0 + i, (i == 1), 4'd4})
        begin errors++; $display("FAIL midrst_beat%0d: got %h/%b/%0d", i, obs[i].d, obs[i].l, obs[i].dest); end
    end
  endtask

  task automatic test_random();
    int n;
    bit ev;
    clr();
    for (int c = 0; c < 600; c++) begin
      usr_valid = $urandom_range(0, 1);
      usr_data = $urandom;
      axis_out_tready = ($urandom_range(0, 3) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_dest = $urandom;
      cmd_id = $urandom;
      cmd_len = $urandom_range(0, 5);
      ev = m_send && (m_q.size() != 0);
      checks++;
      if (axis_out_tvalid !== ev || int'(fifo_count) != m_q.size() ||
          usr_ready !== (m_q.size() < FIFO_DEPTH) || cmd_ready !== !m_send || busy !== m_send)
        begin errors++; $display("FAIL rand_ctrl%0d: tv=%b cnt=%0d ur=%b cr=%b busy=%b want %b %0d %b %b %b",
          c, axis_out_tvalid, fifo_count, usr_ready, cmd_ready, busy,
          ev, m_q.size(), (m_q.size() < FIFO_DEPTH), !m_send, m_send); end
      if (ev) begin
        checks++;
        if ({axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest} !==
            {m_q[0], (m_beat == m_len), m_id, m_dest})
          begin errors++; $display("FAIL rand_beat%0d: td=%h tl=%b tid=%0d tdest=%0d want %h %b %0d %0d",
            c, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest,
            m_q[0], (m_beat == m_len), m_id, m_dest); end
      end
      step();
    end
    cmd_valid = 1'b0;
    axis_out_tready = 1'b1;
    n = 0;
    while (m_send && n < 200) begin
      usr_valid = 1'b1; usr_data = $urandom; step(); n++;
    end
    usr_valid = 1'b0;
    checks++;
    if (n >= 200 || obs != exp_q)
      begin errors++; $display("FAIL rand_stream: cycles=%0d beats=%0d model %0d", n, obs.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full_stall();
    test_underflow();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_noc_tx.md
Name: axis_noc_tx

Overview:
- User-side injection endpoint for a NoC router input port.
- Buffers user data words in a small FIFO and accepts one packet command at a time: destination, ID, length.
- Emits that packet as an AXI-Stream burst on the router's axis_in lane, with stable tdest/tid and a correct tlast.
- Mirror of the router's axis_out lane handling: this block is the transmitter feeding one router port.

Parameters:
- DATA_W, 32, width of tdata and of the user data word.
- TID_W, 2, width of tid.
- TDEST_W, 4, width of tdest (router node address).
- FIFO_DEPTH, 8, data FIFO entries; power of two, at least 2.
- LEN_W, 8, width of the packet length field; a packet is 1..2^LEN_W beats.

Ports:
- clk_noc  in  1  NoC clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- usr_valid  in  1  user data word valid.
- usr_ready  out  1  FIFO can accept a word.
- usr_data  in  DATA_W  user data word.
- cmd_valid  in  1  packet command valid.
- cmd_ready  out  1  command accepted this cycle when both high.
- cmd_dest  in  TDEST_W  packet destination.
- cmd_id  in  TID_W  packet ID.
- cmd_len  in  LEN_W  beats minus one.
- axis_out_tvalid  out  1  AXIS valid toward router.
- axis_out_tready  in  1  AXIS ready from router.
- axis_out_tdata  out  DATA_W  FIFO head word.
- axis_out_tlast  out  1  final beat of packet.
- axis_out_tid  out  TID_W  latched cmd_id.
- axis_out_tdest  out  TDEST_W  latched cmd_dest.
- busy  out  1  high in SEND.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, immediate) clears the following:
  - state to IDLE; FIFO pointers and count to 0; beat counter to 0.
  - axis_out_tvalid, axis_out_tlast and busy to 0.
  - axis_out_tid, axis_out_tdest and axis_out_tdata to 0.
  - usr_ready goes to 1 and cmd_ready goes to 1 after reset deasserts.
- FIFO:
  - usr_ready = (count != FIFO_DEPTH).
  - Push on usr_valid & usr_ready.
  - Pop on axis_out_tvalid & axis_out_tready.
  - Simultaneous push and pop leaves count unchanged.
  - No bypass: a word pushed at edge N is visible at the head from cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM, two states:
  - IDLE: cmd_ready = 1 and axis_out_tvalid = 0. On cmd_valid, latch cmd_dest, cmd_id and cmd_len into registers, clear the beat counter, and go to SEND.
  - SEND: cmd_ready = 0. axis_out_tvalid = (count != 0). axis_out_tlast = tvalid & (beat_cnt == len_reg). Each handshake increments beat_cnt. A handshake with tlast = 1 returns to IDLE at that edge.
- Throughput:
  - There is one IDLE bubble between packets.
  - The next command can be accepted in the cycle after the last beat.
  - Within a packet the block sustains 1 beat/cycle whenever the FIFO is non-empty and tready is high.
- AXIS rules:
  - Once tvalid is high, tdata, tlast, tid and tdest hold stable until the handshake.
  - tvalid never drops without a handshake, because only a pop can empty the FIFO.
  - tid and tdest stay constant for the whole packet.
- Commands are ignored outside IDLE, because cmd_ready is low.
- Data beyond the current packet length stays in the FIFO for the next packet.
- Words pushed while IDLE are retained; no data is dropped.
- cmd_len = 0 produces a single-beat packet with tlast on beat 0.
- cmd_len = 2^LEN_W-1 produces 2^LEN_W beats; the beat counter is LEN_W bits and must not overflow before the tlast compare.
- FIFO full plus stalled tready: usr_ready = 0 and the head word is held.
- Reset asserted mid-packet:
  - tvalid drops asynchronously and FIFO contents are discarded.
  - The partial packet is truncated; the router side must tolerate this on reset only.

Test Plan:
- Push 4 words 0xA0..0xA3, then command dest=5, id=2, len=3, with tready tied high -> 4 consecutive beats 0xA0..0xA3 with tdest=5 and tid=2; tlast only on 0xA3; busy falls after the last beat; cmd_ready returns the next cycle.
- Command len=0 with the FIFO holding 1 word 0x11 -> single beat 0x11 with tlast=1; FSM back in IDLE.
- Fill the FIFO to 8 words with tready=0 during SEND -> usr_ready=0 and fifo_count=8; tdata holds the head word stable for 10 stall cycles; on releasing tready all 8 words drain in order.
- Command len=5 with only 2 words buffered, then 4 more pushed one every 3 cycles -> tvalid deasserts only while the FIFO is empty; 6 beats in order with tlast on the 6th.
- Push 6 words, command len=2, then command len=2 again -> two 3-beat packets with one IDLE bubble cycle between them; tid/tdest update only at the second cmd acceptance.
- Assert rst after beat 2 of a len=7 packet -> tvalid=0 in the same cycle; fifo_count=0; after release a fresh command and data produce a correct new packet.
